// File: rtl/inst_dispatch.sv
// inst_dispatch: per-channel instruction FIFOs issuing to peripherals when they report ready
module inst_dispatch #(
  parameter int CHANNELS   = 4,
  parameter int INST_WIDTH = 12,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [INST_WIDTH-1:0]          inst,
  input  logic [CHANNELS-1:0]            inst_wen,
  input  logic [CHANNELS-1:0]            dev_ready,
  input  logic [CHANNELS-1:0]            overflow_clr,
  output logic [INST_WIDTH*CHANNELS-1:0] dev_inst,
  output logic [CHANNELS-1:0]            dev_inst_en,
  output logic [CHANNELS-1:0]            full,
  output logic [CHANNELS-1:0]            empty,
  output logic [CHANNELS-1:0]            overflow
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [ADDR_WIDTH:0] full_cnt = (ADDR_WIDTH+1)'(DEPTH);
  genvar c;
  for (c = 0; c < CHANNELS; c++) begin : g_ch
    logic [INST_WIDTH-1:0] mem [DEPTH];
    logic [INST_WIDTH-1:0] out_q;
    logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  en_q, ovf_q, pop, push, drop;
    state_t                state;
    assign full[c]  = count == full_cnt;
    assign empty[c] = count == '0;
    assign pop  = state == IDLE && !empty[c] && dev_ready[c];
    // a full FIFO still accepts a write when the head leaves on the same edge
    assign push = inst_wen[c] && (!full[c] || pop);
    assign drop = inst_wen[c] && !push;
    assign dev_inst[c*INST_WIDTH +: INST_WIDTH] = out_q;
    assign dev_inst_en[c] = en_q;
    assign overflow[c]    = ovf_q;
    always_ff @(posedge clock)
      if (push) mem[wr_ptr] <= inst;
    always_ff @(posedge clock or posedge reset)
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        out_q  <= '0;
        en_q   <= 1'b0;
        ovf_q  <= 1'b0;
        state  <= IDLE;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (pop) out_q <= mem[rd_ptr];
        count <= count + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
        ovf_q <= drop | (ovf_q & ~overflow_clr[c]);
        en_q  <= pop;
        state <= pop ? HOLD : IDLE;
      end
  end
endmodule

// File: doc/inst_dispatch.md
Name: inst_dispatch

Overview:
- Parametrised successor to the direct sequencer-oreg-to-peripheral wiring. Sits between Seq (oreg/oreg_wen) and N instruction-driven peripherals (DdrCtl1, LedBank, Swc, ...).
- Each channel has a DEPTH-entry instruction FIFO. Instructions are forwarded only when that channel's peripheral reports ready, so the sequencer no longer has to poll ready before every write.
- Per-channel full/empty/overflow status is exported so it can be fed back to Seq ireg inputs.

Parameters:
- CHANNELS, 4, number of peripheral channels (1..8)
- INST_WIDTH, 12, instruction word width
- DEPTH, 4, FIFO entries per channel; must be a power of two, >= 2
- ADDR_WIDTH, 2, log2(DEPTH)

Ports:
- clock  in  1  single system clock, all state rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- inst  in  INST_WIDTH  instruction word from sequencer oreg
- inst_wen  in  CHANNELS  per-channel write enable; multiple bits may be set, and the same word is pushed into each selected channel
- dev_ready  in  CHANNELS  peripheral i can accept an instruction
- overflow_clr  in  CHANNELS  clears sticky overflow[i]
- dev_inst  out  INST_WIDTH*CHANNELS  channel i occupies bits [i*INST_WIDTH +: INST_WIDTH]
- dev_inst_en  out  CHANNELS  one-cycle issue strobe to peripheral i
- full  out  CHANNELS  count[i] == DEPTH
- empty  out  CHANNELS  count[i] == 0
- overflow  out  CHANNELS  sticky: a write to channel i was dropped

Behaviour:
- Reset (asynchronous, any time including mid-transfer):
  - all FIFOs emptied, contents discarded
  - pointers and counts 0, all channel FSMs to IDLE
  - dev_inst=0, dev_inst_en=0, overflow=0, full=0, empty=all ones
- Channels are fully independent; no arbitration between channels.
- FIFO per channel:
  - circular buffer with ADDR_WIDTH-bit rd/wr pointers that wrap modulo DEPTH
  - count is ADDR_WIDTH+1 bits
  - full and empty are decoded combinationally from the registered count
- Push at an edge where inst_wen[i]=1:
  - accepted if count<DEPTH, or count==DEPTH and a pop occurs at the same edge
  - otherwise the word is dropped, overflow[i] is set, and pointers and count are unchanged
- Simultaneous push and pop: count unchanged, both pointers advance.
- overflow[i]: set by a dropped write, cleared by overflow_clr[i]. If both happen at the same edge, set wins.
- Channel FSM, all outputs registered:
  - IDLE: if !empty[i] && dev_ready[i] at the edge, then dev_inst[i] <= FIFO head, dev_inst_en[i] <= 1, pop, and go to HOLD. Otherwise dev_inst_en[i] <= 0 and stay in IDLE.
  - HOLD: dev_inst_en[i] <= 0; dev_ready[i] is ignored (one-cycle guard while the peripheral drops ready); go to IDLE.
  - dev_inst[i] holds its last issued value between issues and is only updated on issue.
- Timing:
  - Latency: inst_wen[i] sampled at edge k into an empty FIFO with dev_ready[i]=1 gives dev_inst_en[i] high for exactly the cycle after edge k+1, with dev_inst valid in that same cycle.
  - Max throughput per channel: one issue per 2 cycles.
  - dev_inst_en[i] is never high in two consecutive cycles.
- A write into an empty FIFO is never bypassed; it always passes through storage.
- If dev_ready[i] stays low, the FIFO holds its data indefinitely; no timeout.

Test Plan:
- Reset, then inst=12'hA5C, inst_wen=4'b0001, dev_ready=4'b1111 -> dev_inst_en[0] high for one cycle after the second edge, dev_inst[11:0]=12'hA5C, empty[0] back to 1, other channels idle.
- dev_ready[1]=0; write 12'h001..12'h004 to channel 1 -> full[1]=1 after the 4th write; a 5th write of 12'h005 -> overflow[1]=1 and contents unchanged. Then raise dev_ready[1] -> issues 001,002,003,004 in order, spaced 2 cycles apart.
- Channel 2 full with dev_ready=1: write at the same edge as a pop -> write accepted, count stays 4, overflow[2] stays 0.
- inst_wen=4'b1010, inst=12'h7FF -> channels 1 and 3 each issue 12'h7FF in the same cycle; channels 0 and 2 untouched.
- overflow_clr[1] and a dropped write on channel 1 at the same edge -> overflow[1] stays 1; overflow_clr[1] alone -> 0.
- Assert reset with channel 0 holding 3 entries in HOLD state -> all outputs at reset values immediately; after release, no stale issue occurs.
